video_timing_detector: RTL and testbench
========================================

VIDEO_TIMING_DETECTOR -- requirements
Module: video_timing_detector

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of all period/pulse/position counters and outputs.
REQ-002 SHALL have parameter LOCK_FRAMES, default 2, meaning consecutive matching frames required to assert locked.
REQ-003 SHALL have port pixel_clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  high = operate; low = hold all state and outputs.
REQ-006 SHALL have ports h_sync_in, v_sync_in  input  1 each  asynchronous external syncs, either polarity.
REQ-007 SHALL have ports h_period, h_pulse  output  CNT_W each  line length and sync width in pixel clocks.
REQ-008 SHALL have ports v_period, v_pulse  output  CNT_W each  frame length and sync width in lines.
REQ-009 SHALL have ports h_pol, v_pol  output  1 each  detected active sync level.
REQ-010 SHALL have port locked  output  1  stable timing detected.
REQ-011 SHALL have ports h_pos, v_pos  output  CNT_W each  position counted from the sync rising edge.

Function
REQ-012 SHALL pass each sync input through a 2-flop synchronizer; edge detection uses the synchronized signals.
REQ-013 SHALL define a line event as a rising edge of synchronized h_sync, and a frame event as a rising edge of synchronized v_sync.
REQ-014 SHALL count pixel clocks between consecutive line events (P) and clocks with the sync high (H), both saturating at all-ones.
REQ-015 SHALL, one cycle after each line event following a complete period: h_period=P, h_pulse=min(H,P-H), h_pol=(H<=P-H).
REQ-016 SHALL count line events between consecutive frame events (L) and line events seen with v_sync high (VH), both saturating.
REQ-017 SHALL, one cycle after each frame event following a complete frame: v_period=L, v_pulse=min(VH,L-VH), v_pol=(VH<=L-VH).
REQ-018 SHALL run FSM SEARCH -> MEASURE -> LOCKED; locked=1 only in LOCKED.
REQ-019 SHALL move SEARCH->MEASURE on the first frame event after the first complete line.
REQ-020 SHALL, in MEASURE on each frame event, increment a match count if (h_period,v_period) equals the previous frame's values, else clear it; LOCKED is entered when match count reaches LOCK_FRAMES.
REQ-021 SHALL leave LOCKED for MEASURE (match count 0, locked=0 next cycle) on a frame event with changed h_period or v_period.
REQ-022 SHALL return to SEARCH from any state when P saturates (no line event for 2^CNT_W-1 clocks); outputs h/v period, pulse, pol are then cleared to 0.
REQ-023 SHALL, with en low, freeze all counters, FSM and outputs; edges occurring while en is low are not detected.
REQ-024 SHALL treat a line event coinciding with a frame event as both: the line is counted in L before v_period is latched.

Reset
REQ-025 SHALL on reset: synchronizers, counters, match count, all outputs = 0; FSM = SEARCH; reset overrides en.
REQ-026 SHALL require a full line and a full frame after reset release before any measurement updates (first partial period is discarded).

Configuration
REQ-027 SHALL compile the h_pos/v_pos reconstruction only when macro VIDEO_TIMING_DETECTOR_POS_EN is defined: h_pos clears to 0 on the cycle after a line event, then increments, saturating; v_pos clears to 0 on a frame event, increments on each line event.
REQ-028 SHALL tie h_pos and v_pos to constant 0 when VIDEO_TIMING_DETECTOR_POS_EN is undefined; all other behaviour is identical.

Verification
REQ-029 SHALL cover: 800x600 stimulus (h 1056 clk, pulse 128 high; v 628 lines, pulse 4 high) -> h_period=1056, h_pulse=128, h_pol=1, v_period=628, v_pulse=4, v_pol=1, locked=1 at the frame event after 2 matching frames.
REQ-030 SHALL cover: same timing with both syncs inverted -> identical period/pulse values, h_pol=0, v_pol=0, locked=1.
REQ-031 SHALL cover: locked, then h period changed to 1040 -> locked=0 after next frame event; relocks with h_period=1040 after 2 further matching frames.
REQ-032 SHALL cover: locked, then h_sync_in held constant for 65535 clocks -> FSM SEARCH, locked=0, all period/pulse/pol outputs 0.
REQ-033 SHALL cover: reset pulsed mid-frame -> all outputs 0 next cycle; en low for 500 clocks while locked -> outputs unchanged throughout.
REQ-034 SHALL cover, with VIDEO_TIMING_DETECTOR_POS_EN defined: h_pos=0 three cycles after an h_sync_in rising edge, reaching 1055 before the next clear; v_pos wraps to 0 at each frame event.

Source files
------------

// File: rtl/video_timing_detector.sv
// video_timing_detector: measures line/frame period, sync pulse width and sync
// polarity from asynchronous h/v syncs, and raises locked once timing is stable.
// Optional h_pos/v_pos reconstruction is built only with VIDEO_TIMING_DETECTOR_POS_EN.
module video_timing_detector #(
  parameter int CNT_W       = 16,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             h_sync_in,
  input  logic             v_sync_in,
  output logic [CNT_W-1:0] h_period,
  output logic [CNT_W-1:0] h_pulse,
  output logic [CNT_W-1:0] v_period,
  output logic [CNT_W-1:0] v_pulse,
  output logic             h_pol,
  output logic             v_pol,
  output logic             locked,
  output logic [CNT_W-1:0] h_pos,
  output logic [CNT_W-1:0] v_pos
);

  localparam int               MW        = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [MW-1:0]    MATCH_TGT = MW'(LOCK_FRAMES);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic inc);
    return (inc && (val != CNT_MAX)) ? val + CNT_ONE : val;
  endfunction

  // ---------------------------------------------------------------------------
  // Sync input synchronizers and rising-edge detection
  // ---------------------------------------------------------------------------
  logic h_meta_q, h_sync_q, h_dly_q;
  logic v_meta_q, v_sync_q, v_dly_q;

  // Two-flop synchronizers plus one delay stage for edge detection. These keep
  // running while en is low so edges that happen during the freeze are absorbed
  // and never reported once en returns.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      h_meta_q <= 1'b0;
      h_sync_q <= 1'b0;
      h_dly_q  <= 1'b0;
      v_meta_q <= 1'b0;
      v_sync_q <= 1'b0;
      v_dly_q  <= 1'b0;
    end else begin
      h_meta_q <= h_sync_in;
      h_sync_q <= h_meta_q;
      h_dly_q  <= h_sync_q;
      v_meta_q <= v_sync_in;
      v_sync_q <= v_meta_q;
      v_dly_q  <= v_sync_q;
    end
  end

  logic line_evt, frame_evt;
  assign line_evt  = en & h_sync_q & ~h_dly_q;
  assign frame_evt = en & v_sync_q & ~v_dly_q;

  // ---------------------------------------------------------------------------
  // Horizontal measurement
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] p_cnt_q;      // clocks since last line event
  logic [CNT_W-1:0] h_hi_q;       // clocks with sync high in the current line
  logic             line_seen_q;  // a line event opened the current period
  logic             h_vld_q;      // at least one complete line measured
  logic [CNT_W-1:0] h_period_q, h_pulse_q;
  logic             h_pol_q;

  logic             p_sat;
  logic             h_upd;
  logic [CNT_W-1:0] h_diff;
  logic             h_hi_short;
  logic [CNT_W-1:0] h_new;

  // Losing line events for a full counter range means the source is gone.
  assign p_sat      = (p_cnt_q == CNT_MAX);
  assign h_upd      = line_evt & line_seen_q;
  assign h_diff     = p_cnt_q - h_hi_q;
  assign h_hi_short = (h_hi_q <= h_diff);
  assign h_new      = h_upd ? p_cnt_q : h_period_q;

  // Line period / high-time counters and the registered horizontal results.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      p_cnt_q     <= '0;
      h_hi_q      <= '0;
      line_seen_q <= 1'b0;
      h_vld_q     <= 1'b0;
      h_period_q  <= '0;
      h_pulse_q   <= '0;
      h_pol_q     <= 1'b0;
    end else if (en) begin
      if (line_evt) begin
        // The event cycle itself is the first clock of the new line and the
        // synchronized sync is high on it.
        p_cnt_q     <= CNT_ONE;
        h_hi_q      <= CNT_ONE;
        line_seen_q <= 1'b1;
      end else begin
        p_cnt_q <= sat_inc(p_cnt_q, 1'b1);
        h_hi_q  <= sat_inc(h_hi_q, h_sync_q);
      end

      if (p_sat) begin
        line_seen_q <= 1'b0;
        h_vld_q     <= 1'b0;
        h_period_q  <= '0;
        h_pulse_q   <= '0;
        h_pol_q     <= 1'b0;
      end else if (h_upd) begin
        h_vld_q    <= 1'b1;
        h_period_q <= p_cnt_q;
        h_pulse_q  <= h_hi_short ? h_hi_q : h_diff;
        h_pol_q    <= h_hi_short;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vertical measurement
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] l_cnt_q;       // line events since last frame event
  logic [CNT_W-1:0] vh_cnt_q;      // of those, lines seen with v_sync high
  logic             frame_seen_q;  // a frame event opened the current frame
  logic [CNT_W-1:0] v_period_q, v_pulse_q;
  logic             v_pol_q;

  logic [CNT_W-1:0] l_fin, vh_fin, v_diff;
  logic             v_upd;
  logic             v_hi_short;

  // A line event on the frame-event cycle still belongs to the closing frame.
  assign l_fin      = sat_inc(l_cnt_q, line_evt);
  assign vh_fin     = sat_inc(vh_cnt_q, line_evt & v_sync_q);
  assign v_diff     = l_fin - vh_fin;
  assign v_hi_short = (vh_fin <= v_diff);
  assign v_upd      = frame_evt & frame_seen_q;

  // Frame line counters and the registered vertical results.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      l_cnt_q      <= '0;
      vh_cnt_q     <= '0;
      frame_seen_q <= 1'b0;
      v_period_q   <= '0;
      v_pulse_q    <= '0;
      v_pol_q      <= 1'b0;
    end else if (en) begin
      if (p_sat) begin
        l_cnt_q      <= '0;
        vh_cnt_q     <= '0;
        frame_seen_q <= 1'b0;
        v_period_q   <= '0;
        v_pulse_q    <= '0;
        v_pol_q      <= 1'b0;
      end else if (frame_evt) begin
        l_cnt_q      <= '0;
        vh_cnt_q     <= '0;
        frame_seen_q <= 1'b1;
        if (frame_seen_q) begin
          v_period_q <= l_fin;
          v_pulse_q  <= v_hi_short ? vh_fin : v_diff;
          v_pol_q    <= v_hi_short;
        end
      end else begin
        l_cnt_q  <= l_fin;
        vh_cnt_q <= vh_fin;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [MW-1:0]    match_q;
  logic             locked_q;
  logic [CNT_W-1:0] prev_h_q, prev_v_q;
  logic             prev_vld_q;

  logic             frame_match;
  logic [MW-1:0]    match_inc;

  // Compare against what this frame event is about to publish, so a line event
  // landing on the same cycle is already reflected in the horizontal value.
  assign frame_match = prev_vld_q && (h_new == prev_h_q) && (l_fin == prev_v_q);
  assign match_inc   = match_q + MATCH_ONE;

  // SEARCH waits for a measured line, MEASURE counts repeated frames, LOCKED
  // holds until timing changes or the line source disappears.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q    <= ST_SEARCH;
      match_q    <= '0;
      locked_q   <= 1'b0;
      prev_h_q   <= '0;
      prev_v_q   <= '0;
      prev_vld_q <= 1'b0;
    end else if (en) begin
      if (p_sat) begin
        state_q    <= ST_SEARCH;
        match_q    <= '0;
        locked_q   <= 1'b0;
        prev_vld_q <= 1'b0;
      end else begin
        if (v_upd) begin
          prev_h_q   <= h_new;
          prev_v_q   <= l_fin;
          prev_vld_q <= 1'b1;
        end
        case (state_q)
          ST_SEARCH: begin
            if (frame_evt && (h_vld_q || h_upd)) begin
              state_q <= ST_MEASURE;
              match_q <= '0;
            end
          end
          ST_MEASURE: begin
            if (v_upd) begin
              if (frame_match) begin
                match_q <= match_inc;
                if (match_inc >= MATCH_TGT) begin
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
                end
              end else begin
                match_q <= '0;
              end
            end
          end
          ST_LOCKED: begin
            if (v_upd && !frame_match) begin
              state_q  <= ST_MEASURE;
              match_q  <= '0;
              locked_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= ST_SEARCH;
            match_q  <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional raster position
  // ---------------------------------------------------------------------------
`ifdef VIDEO_TIMING_DETECTOR_POS_EN
  logic [CNT_W-1:0] h_pos_q, v_pos_q;

  // h_pos restarts the cycle after each line event; v_pos restarts on the
  // frame event and otherwise advances once per line event.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      h_pos_q <= '0;
      v_pos_q <= '0;
    end else if (en) begin
      h_pos_q <= line_evt ? '0 : sat_inc(h_pos_q, 1'b1);
      if (frame_evt) begin
        v_pos_q <= '0;
      end else begin
        v_pos_q <= sat_inc(v_pos_q, line_evt);
      end
    end
  end

  assign h_pos = h_pos_q;
  assign v_pos = v_pos_q;
`else
  assign h_pos = '0;
  assign v_pos = '0;
`endif

  assign h_period = h_period_q;
  assign h_pulse  = h_pulse_q;
  assign h_pol    = h_pol_q;
  assign v_period = v_period_q;
  assign v_pulse  = v_pulse_q;
  assign v_pol    = v_pol_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_video_timing_detector.sv
// Bench for video_timing_detector: scaled-down raster timings drive the syncs,
// expected measurements are queued per scenario and checked when locked rises,
// and hand sequences cover relock, enable freeze, reset, timeout and position.
module tb_video_timing_detector;

  localparam int CNT_W       = 12;
  localparam int LOCK_FRAMES = 2;

  logic             pixel_clk = 1'b0;
  logic             reset     = 1'b1;
  logic             en        = 1'b1;
  logic             h_sync_in = 1'b0;
  logic             v_sync_in = 1'b0;
  logic [CNT_W-1:0] h_period, h_pulse, v_period, v_pulse, h_pos, v_pos;
  logic             h_pol, v_pol, locked;

  video_timing_detector #(.CNT_W(CNT_W), .LOCK_FRAMES(LOCK_FRAMES)) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .en        (en),
    .h_sync_in (h_sync_in),
    .v_sync_in (v_sync_in),
    .h_period  (h_period),
    .h_pulse   (h_pulse),
    .v_period  (v_period),
    .v_pulse   (v_pulse),
    .h_pol     (h_pol),
    .v_pol     (v_pol),
    .locked    (locked),
    .h_pos     (h_pos),
    .v_pos     (v_pos)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int hp; int hw; int hpol;
    int vp; int vw; int vpol;
  } exp_t;

  typedef struct {
    int   h_tot; int h_pw; int v_tot; int v_pw;
    bit   inv_h; bit inv_v;
    exp_t e;
    int   lock_frame;   // frame index in which locked must rise, -1 = not checked
  } vec_t;

  // raster generator state
  int   h_tot, h_pw, v_tot, v_pw;
  bit   inv_h, inv_v;
  int   hc, vc;
  int   tcount;
  bit   lk_prev;
  int   t_lock, t_unlock;
  exp_t exp_q[$];
  int   n_chk, n_fail;
  vec_t vecs[5];

  function automatic exp_t mk_exp(int hp, int hw, int hpol, int vp, int vw, int vpol);
    exp_t e;
    e.hp = hp; e.hw = hw; e.hpol = hpol; e.vp = vp; e.vw = vw; e.vpol = vpol;
    return e;
  endfunction

  function automatic vec_t mk_vec(int ht, int hw, int vt, int vw, bit ih, bit iv, exp_t e, int lf);
    vec_t v;
    v.h_tot = ht; v.h_pw = hw; v.v_tot = vt; v.v_pw = vw;
    v.inv_h = ih; v.inv_v = iv; v.e = e; v.lock_frame = lf;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    h_tot = v.h_tot; h_pw = v.h_pw; v_tot = v.v_tot; v_pw = v.v_pw;
    inv_h = v.inv_h; inv_v = v.inv_v;
  endtask

  // Scoreboard side: a rising locked consumes the next expected measurement.
  task automatic monitor();
    exp_t e;
    if (locked && !lk_prev) begin
      t_lock = tcount;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("lock_h_period", int'(h_period), e.hp);
        chk("lock_h_pulse",  int'(h_pulse),  e.hw);
        chk("lock_h_pol",    int'(h_pol),    e.hpol);
        chk("lock_v_period", int'(v_period), e.vp);
        chk("lock_v_pulse",  int'(v_pulse),  e.vw);
        chk("lock_v_pol",    int'(v_pol),    e.vpol);
      end
    end
    if (!locked && lk_prev) t_unlock = tcount;
    lk_prev = locked;
  endtask

  // One clock: sample at the falling edge, then drive the next raster sample.
  task automatic tick();
    @(negedge pixel_clk);
    monitor();
    h_sync_in = (hc < h_pw) ^ inv_h;
    v_sync_in = (vc < v_pw) ^ inv_v;
    hc++;
    if (hc >= h_tot) begin
      hc = 0;
      vc++;
      if (vc >= v_tot) vc = 0;
    end
    tcount++;
  endtask

  task automatic do_reset();
    @(negedge pixel_clk);
    reset = 1'b1;
    en = 1'b1;
    h_sync_in = inv_h;
    v_sync_in = inv_v;
    repeat (3) @(negedge pixel_clk);
    reset = 1'b0;
    hc = 0;
    vc = 0;
  endtask

  task automatic run_until_lock(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      chk({name, "_lock_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic align_frame_start(input string name);
    int n;
    n = 0;
    while (!(hc == 0 && vc == 0) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) chk({name, "_align_timeout"}, n, 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_h_period"}, int'(h_period), 0);
    chk({name, "_h_pulse"},  int'(h_pulse),  0);
    chk({name, "_h_pol"},    int'(h_pol),    0);
    chk({name, "_v_period"}, int'(v_period), 0);
    chk({name, "_v_pulse"},  int'(v_pulse),  0);
    chk({name, "_v_pol"},    int'(v_pol),    0);
    chk({name, "_locked"},   int'(locked),   0);
  endtask

  initial begin
    int start;
    int bad;
    n_chk = 0; n_fail = 0; tcount = 0; lk_prev = 1'b0;
    t_lock = -1; t_unlock = -1;

    // {h_tot, h_pw, v_tot, v_pw, inv_h, inv_v, expected, lock frame}
    vecs[0] = mk_vec(40, 6, 10, 2, 1'b0, 1'b0, mk_exp(40, 6, 1, 10, 2, 1), 3);
    vecs[1] = mk_vec(40, 6, 10, 2, 1'b1, 1'b1, mk_exp(40, 6, 0, 10, 2, 0), -1);
    vecs[2] = mk_vec(32, 4,  8, 3, 1'b0, 1'b1, mk_exp(32, 4, 1,  8, 3, 0), -1);
    vecs[3] = mk_vec(50, 10, 6, 1, 1'b1, 1'b0, mk_exp(50, 10, 0, 6, 1, 1), -1);
    vecs[4] = mk_vec(20, 10, 4, 2, 1'b0, 1'b0, mk_exp(20, 10, 1, 4, 2, 1), 3);

    // reset state
    set_cfg(vecs[0]);
    do_reset();
    chk_all_zero("reset");
    chk("reset_h_pos", int'(h_pos), 0);
    chk("reset_v_pos", int'(v_pos), 0);

    // table-driven timings: measurement and lock point
    for (int i = 0; i < 5; i++) begin
      set_cfg(vecs[i]);
      do_reset();
      exp_q.push_back(vecs[i].e);
      start = tcount;
      t_lock = -1;
      run_until_lock($sformatf("vec%0d", i), 12 * h_tot * v_tot);
      if (vecs[i].lock_frame >= 0)
        chk($sformatf("vec%0d_lock_frame", i), (t_lock - start) / (h_tot * v_tot),
            vecs[i].lock_frame);
    end

    // line length change while locked: drop lock, relock two frames later
    set_cfg(vecs[0]);
    do_reset();
    exp_q.push_back(vecs[0].e);
    run_until_lock("hchg_first", 12 * 400);
    align_frame_start("hchg");
    h_tot = 36;
    exp_q.push_back(mk_exp(36, 6, 1, 10, 2, 1));
    t_unlock = -1;
    t_lock = -1;
    for (int n = 0; n < 800 && locked; n++) tick();
    chk("hchg_unlocked", int'(locked), 0);
    run_until_lock("hchg_relock", 8 * 360);
    chk("hchg_relock_gap", t_lock - t_unlock, 720);
`ifdef VIDEO_TIMING_DETECTOR_POS_EN
`else
    chk("tied_h_pos", int'(h_pos), 0);
    chk("tied_v_pos", int'(v_pos), 0);
`endif

    // enable low while locked: everything holds even as syncs keep toggling
    en = 1'b0;
    bad = 0;
    for (int n = 0; n < 500; n++) begin
      tick();
      if (int'(h_period) != 36 || int'(h_pulse) != 6 || h_pol !== 1'b1 ||
          int'(v_period) != 10 || int'(v_pulse) != 2 || v_pol !== 1'b1 || locked !== 1'b1)
        bad++;
    end
    chk("en_low_changed_cycles", bad, 0);
    en = 1'b1;

    // synchronous reset mid-frame clears outputs on the next cycle
    chk("pre_reset_locked", int'(locked), 1);
    reset = 1'b1;
    tick();
    chk_all_zero("midreset");
    chk("midreset_h_pos", int'(h_pos), 0);
    chk("midreset_v_pos", int'(v_pos), 0);
    reset = 1'b0;

    // line source disappears: hold until the period counter saturates
    set_cfg(vecs[0]);
    do_reset();
    exp_q.push_back(vecs[0].e);
    run_until_lock("sat_lock", 12 * 400);
    while (hc != h_pw) tick();
    h_pw = 0;
    v_pw = 0;
    repeat (3900) tick();
    chk("sat_still_locked", int'(locked), 1);
    repeat (300) tick();
    chk_all_zero("sat");

`ifdef VIDEO_TIMING_DETECTOR_POS_EN
    // position reconstruction around a frame start
    set_cfg(vecs[0]);
    do_reset();
    repeat (50) tick();
    align_frame_start("pos");
    tick();
    tick();
    tick();
    chk("pos_h_before_clear", int'(h_pos), 39);
    chk("pos_v_before_wrap",  int'(v_pos), 9);
    tick();
    chk("pos_h_clear", int'(h_pos), 0);
    chk("pos_v_wrap",  int'(v_pos), 0);
    repeat (39) tick();
    chk("pos_h_max", int'(h_pos), 39);
    tick();
    chk("pos_h_clear2", int'(h_pos), 0);
    chk("pos_v_line1", int'(v_pos), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
